seg_scan_ctrl: RTL and testbench

Time-multiplexing scheduler for the shared four-digit seven-segment display on the soc top level. Owns the shared `seg`/`dp` cathode bus and the four `an` anode strobes, and hands each digit a fixed time slot in round-robin order. Includes anti-ghost blanking, 16-step PWM brightness and a tear-free valid/ready load port for the CPU-side register block.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_scan_ctrl_if.sv | 10 +
 rtl/seg_scan_ctrl_hex7seg.sv | 9 +
 rtl/seg_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

    typedef enum logic [1:0] {
        S_BLANK = 2'd0,
        S_ON    = 2'd1,
        S_OFF   = 2'd2
    } seg_state_t;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
    } seg_disp_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low gfedcba, indexed by nibble value
    localparam logic [6:0] HEX7SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// CPU-side valid/ready load port for the display scanner.
interface seg_scan_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;

    modport master (output wr_valid, output wr_data, output wr_dp, input wr_ready);
    modport slave  (input wr_valid, input wr_data, input wr_dp, output wr_ready);
endinterface

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb seg = HEX7SEG[nibble];
endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit time-multiplexed seven-segment scanner with blanking, PWM
// brightness and a shadow/display double-buffered load port.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned SUB_DIV = 3125
)
(
    input  logic            clk,
    input  logic            btnCpuReset,
    seg_scan_ctrl_if.slave  wr,
    input  logic [3:0]      brightness,
    input  logic [3:0]      enable,
    output logic [6:0]      seg,
    output logic            dp,
    output logic [3:0]      an,
    output logic            frame_tick
);
    localparam int unsigned SW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(SUB_DIV - 1);

    logic [SW-1:0] subCnt;
    logic [3:0]    phase;
    logic [1:0]    digit;
    logic          subWrap;
    logic          slotStart;
    logic          frameStart;

    seg_state_t    stateQ;
    seg_state_t    stateNxt;

    seg_disp_t     shadow;
    seg_disp_t     display;
    seg_disp_t     displayNxt;
    logic          pending;
    logic          loadNow;
    logic          acceptNow;

    logic [3:0]    slotNibble;
    logic [3:0]    slotBright;
    logic          slotDp;
    logic          slotEn;
    logic [6:0]    segDec;

    always_comb begin
        subWrap    = (subCnt == SUB_LAST);
        slotStart  = (subCnt == '0) && (phase == '0);
        frameStart = slotStart && (digit == '0);
        loadNow    = frameStart && pending;
        acceptNow  = wr.wr_valid && !pending;
        displayNxt = loadNow ? shadow : display;
    end

    assign wr.wr_ready = !pending;

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            subCnt <= '0;
            phase  <= '0;
            digit  <= '0;
        end else if (subWrap) begin
            subCnt <= '0;
            phase  <= phase + 4'd1;
            if (phase == 4'd15)
                digit <= digit + 2'd1;
        end else begin
            subCnt <= subCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            shadow  <= '0;
            display <= '0;
            pending <= 1'b0;
        end else if (loadNow) begin
            display <= shadow;
            pending <= 1'b0;
        end else if (acceptNow) begin
            shadow  <= '{data: wr.wr_data, dp: wr.wr_dp};
            pending <= 1'b1;
        end
    end

    // Slot 0 samples the incoming display word so a frame-start load shows immediately
    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            slotNibble <= '0;
            slotBright <= '0;
            slotDp     <= 1'b0;
            slotEn     <= 1'b0;
        end else if (slotStart) begin
            slotNibble <= displayNxt.data[{digit, 2'b00} +: 4];
            slotDp     <= displayNxt.dp[digit];
            slotBright <= brightness;
            slotEn     <= enable[digit];
        end
    end

    hex7seg u_hex7seg (
        .nibble (slotNibble),
        .seg    (segDec)
    );

    // stateNxt is the state of the subphase being entered; outputs register it directly
    always_comb begin
        stateNxt = stateQ;
        if (slotStart) begin
            stateNxt = S_BLANK;
        end else if (subCnt == '0) begin
            case (stateQ)
                S_BLANK: if (phase == 4'd1)
                             stateNxt = (slotBright != '0 && slotEn) ? S_ON : S_OFF;
                S_ON:    if ({1'b0, phase} == {1'b0, slotBright} + 5'd1)
                             stateNxt = S_OFF;
                S_OFF:   stateNxt = S_OFF;
                default: stateNxt = S_BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            stateQ     <= S_BLANK;
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            stateQ     <= stateNxt;
            frame_tick <= frameStart;
            if (stateNxt == S_ON) begin
                an  <= ~(4'b0001 << digit);
                seg <= segDec;
                dp  <= ~slotDp;
            end else begin
                an  <= AN_OFF;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with SUB_DIV=4 and a frame-level reference model.
module tb_seg_scan_ctrl;
    localparam int unsigned SUB   = 4;
    localparam int unsigned SLOT  = 16 * SUB;
    localparam int unsigned FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [3:0] brightness = '0;
    logic [3:0] enable = '0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frameTick;

    int nCmp = 0;
    int nBad = 0;

    logic [6:0] hexTab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [3:0] anSeq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    logic [15:0] hsData;
    logic [3:0]  hsDp;

    seg_scan_ctrl_if wrIf ();

    seg_scan_ctrl #(.SUB_DIV(SUB)) dut (
        .clk         (clk),
        .btnCpuReset (rstN),
        .wr          (wrIf),
        .brightness  (brightness),
        .enable      (enable),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_tick  (frameTick)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Reference model: visible position counts cycles since the first edge after release
    logic [3:0]  expAn;
    logic [6:0]  expSeg;
    logic        expDp, expTick, expReady;
    int unsigned mK, mPos, mDig, mPh;
    logic        mPending, mEn, mDpBit, mLit;
    logic [15:0] mShData, mDispData;
    logic [3:0]  mShDp, mDispDp, mB, mNib;

    initial begin
        forever begin
            @(posedge clk or negedge rstN);
            if (rstN !== 1'b1) begin
                mK = 0; mPending = 0; mShData = '0; mDispData = '0; mShDp = '0; mDispDp = '0;
                mB = '0; mEn = 0; mNib = '0; mDpBit = 0;
                expAn = 4'hF; expSeg = 7'h7F; expDp = 1'b1; expTick = 1'b0; expReady = 1'b1;
            end else begin
                mPos = mK % FRAME;
                mK++;
                mDig = mPos / SLOT;
                mPh  = (mPos % SLOT) / SUB;
                if (mPos == 0 && mPending) begin
                    mDispData = mShData; mDispDp = mShDp; mPending = 0;
                end else if (wrIf.wr_valid === 1'b1 && !mPending) begin
                    mShData = wrIf.wr_data; mShDp = wrIf.wr_dp; mPending = 1;
                end
                if (mPos % SLOT == 0) begin
                    mB = brightness; mEn = enable[mDig];
                    mNib = mDispData[4*mDig +: 4]; mDpBit = mDispDp[mDig];
                end
                mLit = (mPh >= 1) && (mPh <= mB) && mEn;
                expAn    = mLit ? anSeq[mDig] : 4'hF;
                expSeg   = mLit ? hexTab[mNib] : 7'h7F;
                expDp    = mLit ? ~mDpBit : 1'b1;
                expTick  = (mPos == 0);
                expReady = !mPending;
            end
        end
    end

    always @(negedge clk) begin
        if (rstN === 1'b1) begin
            nCmp++;
            assert ($countones(~an) <= 1) else begin
                nBad++;
                $display("FAIL anode_overlap: an=%b, required at most one low bit", an);
            end
        end
    end

    task automatic wait_frame_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (frameTick === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0; brightness = 4'd15; enable = 4'hF;
        wrIf.wr_valid = 1'b0; wrIf.wr_data = '0; wrIf.wr_dp = '0;
        repeat (10) @(negedge clk);
        nCmp++;
        if ({an, seg, dp, wrIf.wr_ready, frameTick} !== {4'hF, 7'h7F, 1'b1, 1'b1, 1'b0}) begin
            nBad++;
            $display("FAIL reset_values: got an=%h seg=%h dp=%b rdy=%b tick=%b, want F 7f 1 1 0",
                     an, seg, dp, wrIf.wr_ready, frameTick);
        end
        rstN = 1'b1;
        #1;
        nCmp++;
        if (frameTick !== 1'b0) begin
            nBad++; $display("FAIL reset_tick_early: got %b want 0", frameTick);
        end
        @(negedge clk);
        nCmp++;
        if (frameTick !== 1'b1) begin
            nBad++; $display("FAIL reset_first_tick: got %b want 1", frameTick);
        end
        nCmp++;
        if ({an, seg, dp, frameTick, wrIf.wr_ready} !== {expAn, expSeg, expDp, expTick, expReady}) begin
            nBad++; $display("FAIL reset_model: got %h want %h",
                {an, seg, dp, frameTick, wrIf.wr_ready}, {expAn, expSeg, expDp, expTick, expReady});
        end
        @(negedge clk);
        nCmp++;
        if (frameTick !== 1'b0) begin
            nBad++; $display("FAIL reset_tick_width: got %b want 0", frameTick);
        end
    endtask

    task automatic test_scan_decode();
        bit ok;
        int lit [4];
        logic [6:0] segSeq [4];
        logic [3:0] dpSeq;
        segSeq = '{7'h40, 7'h79, 7'h08, 7'h00};
        dpSeq  = 4'b1110;
        lit    = '{0, 0, 0, 0};
        brightness = 4'd15; enable = 4'hF;
        wait_frame_start(ok);
        nCmp++; if (!ok) begin nBad++; $display("FAIL scan_wait_tick: got none want frame_tick"); end
        wrIf.wr_valid = 1'b1; wrIf.wr_data = 16'h8A10; wrIf.wr_dp = 4'b0001;
        @(negedge clk);
        wrIf.wr_valid = 1'b0;
        nCmp++;
        if (wrIf.wr_ready !== 1'b0) begin nBad++; $display("FAIL scan_ready_drop: got %b want 0", wrIf.wr_ready); end
        wait_frame_start(ok);
        nCmp++; if (!ok) begin nBad++; $display("FAIL scan_wait_tick2: got none want frame_tick"); end
        for (int p = 0; p < FRAME; p++) begin
            if (p > 0) @(negedge clk);
            nCmp++;
            if ({an, seg, dp, frameTick, wrIf.wr_ready} !== {expAn, expSeg, expDp, expTick, expReady}) begin
                nBad++; $display("FAIL scan_model p=%0d: got %h want %h", p,
                    {an, seg, dp, frameTick, wrIf.wr_ready}, {expAn, expSeg, expDp, expTick, expReady});
            end
            if (p % SLOT == 4) begin
                nCmp++;
                if ({an, seg, dp} !== {anSeq[p/SLOT], segSeq[p/SLOT], dpSeq[p/SLOT]}) begin
                    nBad++; $display("FAIL scan_digit%0d: got an=%h seg=%h dp=%b want %h %h %b", p/SLOT,
                        an, seg, dp, anSeq[p/SLOT], segSeq[p/SLOT], dpSeq[p/SLOT]);
                end
            end
            for (int d = 0; d < 4; d++) if (an[d] === 1'b0) lit[d]++;
        end
        for (int d = 0; d < 4; d++) begin
            nCmp++;
            if (lit[d] != 60) begin nBad++; $display("FAIL scan_lit%0d: got %0d want 60", d, lit[d]); end
        end
    endtask

    task automatic test_brightness();
        bit ok;
        int lit [4];
        int want [4];
        logic [3:0] b;
        for (int sc = 0; sc < 4; sc++) begin
            b = 4'($urandom_range(1, 15));
            case (sc)
                0: begin brightness = 4'd3; enable = 4'hF;    want = '{12, 12, 12, 12}; end
                1: begin brightness = 4'd0; enable = 4'hF;    want = '{0, 0, 0, 0}; end
                2: begin brightness = b;    enable = 4'b0101; want = '{4*int'(b), 0, 4*int'(b), 0}; end
                default: begin brightness = 4'd3; enable = 4'hF; want = '{12, 36, 36, 36}; end
            endcase
            lit = '{0, 0, 0, 0};
            wait_frame_start(ok);
            nCmp++; if (!ok) begin nBad++; $display("FAIL br_wait_tick%0d: got none want frame_tick", sc); end
            for (int p = 0; p < FRAME; p++) begin
                if (p > 0) @(negedge clk);
                nCmp++;
                if ({an, seg, dp, frameTick, wrIf.wr_ready} !== {expAn, expSeg, expDp, expTick, expReady}) begin
                    nBad++; $display("FAIL br_model sc=%0d p=%0d: got %h want %h", sc, p,
                        {an, seg, dp, frameTick, wrIf.wr_ready}, {expAn, expSeg, expDp, expTick, expReady});
                end
                for (int d = 0; d < 4; d++) if (an[d] === 1'b0) lit[d]++;
                if (sc == 3 && p == SLOT / 2) brightness = 4'd9;
            end
            for (int d = 0; d < 4; d++) begin
                nCmp++;
                if (lit[d] != want[d]) begin
                    nBad++; $display("FAIL br_lit sc=%0d d=%0d: got %0d want %0d", sc, d, lit[d], want[d]);
                end
            end
        end
    endtask

    task automatic test_handshake();
        bit ok;
        hsData = 16'($urandom); hsDp = 4'($urandom);
        brightness = 4'd15; enable = 4'hF;
        wait_frame_start(ok);
        nCmp++; if (!ok) begin nBad++; $display("FAIL hs_wait_tick: got none want frame_tick"); end
        wrIf.wr_valid = 1'b1; wrIf.wr_data = hsData; wrIf.wr_dp = hsDp;
        for (int p = 1; p < FRAME; p++) begin
            @(negedge clk);
            nCmp++;
            if ({an, seg, dp, frameTick, wrIf.wr_ready} !== {expAn, expSeg, expDp, expTick, expReady}) begin
                nBad++; $display("FAIL hs_model p=%0d: got %h want %h", p,
                    {an, seg, dp, frameTick, wrIf.wr_ready}, {expAn, expSeg, expDp, expTick, expReady});
            end
            nCmp++;
            if (wrIf.wr_ready !== 1'b0) begin nBad++; $display("FAIL hs_ready_low p=%0d: got %b want 0", p, wrIf.wr_ready); end
            if (p == 1) begin wrIf.wr_data = ~hsData; wrIf.wr_dp = ~hsDp; end
            if (p == 200) wrIf.wr_valid = 1'b0;
        end
        @(negedge clk);
        nCmp++;
        if ({frameTick, wrIf.wr_ready} !== 2'b11) begin
            nBad++; $display("FAIL hs_ready_at_tick: got tick/rdy=%b want 11", {frameTick, wrIf.wr_ready});
        end
        for (int p = 1; p < FRAME; p++) begin
            @(negedge clk);
            nCmp++;
            if ({an, seg, dp, frameTick, wrIf.wr_ready} !== {expAn, expSeg, expDp, expTick, expReady}) begin
                nBad++; $display("FAIL hs_model2 p=%0d: got %h want %h", p,
                    {an, seg, dp, frameTick, wrIf.wr_ready}, {expAn, expSeg, expDp, expTick, expReady});
            end
            if (p % SLOT == 4) begin
                nCmp++;
                if ({an, seg, dp} !== {anSeq[p/SLOT], hexTab[hsData[4*(p/SLOT) +: 4]], ~hsDp[p/SLOT]}) begin
                    nBad++; $display("FAIL hs_digit%0d: got an=%h seg=%h dp=%b want %h %h %b", p/SLOT, an, seg, dp,
                        anSeq[p/SLOT], hexTab[hsData[4*(p/SLOT) +: 4]], ~hsDp[p/SLOT]);
                end
            end
        end
    endtask

    task automatic test_boundary_write();
        bit ok;
        logic [15:0] c;
        c = 16'($urandom);
        wait_frame_start(ok);
        nCmp++; if (!ok) begin nBad++; $display("FAIL bw_wait_tick: got none want frame_tick"); end
        for (int f = 0; f < 3; f++) begin
            for (int p = 1; p < FRAME; p++) begin
                @(negedge clk);
                nCmp++;
                if ({an, seg, dp, frameTick, wrIf.wr_ready} !== {expAn, expSeg, expDp, expTick, expReady}) begin
                    nBad++; $display("FAIL bw_model f=%0d p=%0d: got %h want %h", f, p,
                        {an, seg, dp, frameTick, wrIf.wr_ready}, {expAn, expSeg, expDp, expTick, expReady});
                end
                if (f > 0 && p == 4) begin
                    nCmp++;
                    if (seg !== ((f == 1) ? hexTab[hsData[3:0]] : hexTab[c[3:0]])) begin
                        nBad++; $display("FAIL bw_digit0 f=%0d: got seg=%h want %h", f, seg,
                            (f == 1) ? hexTab[hsData[3:0]] : hexTab[c[3:0]]);
                    end
                end
                if (f == 0 && p == FRAME - 1) begin
                    wrIf.wr_valid = 1'b1; wrIf.wr_data = c; wrIf.wr_dp = 4'hF;
                end
            end
            if (f < 2) begin
                @(negedge clk);
                wrIf.wr_valid = 1'b0;
                nCmp++;
                if ({frameTick, wrIf.wr_ready} !== ((f == 0) ? 2'b10 : 2'b11)) begin
                    nBad++; $display("FAIL bw_tick f=%0d: got tick/rdy=%b want %b", f,
                        {frameTick, wrIf.wr_ready}, (f == 0) ? 2'b10 : 2'b11);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 4 * FRAME; p++) begin
            @(negedge clk);
            nCmp++;
            if ({an, seg, dp, frameTick, wrIf.wr_ready} !== {expAn, expSeg, expDp, expTick, expReady}) begin
                nBad++; $display("FAIL rnd_model p=%0d: got %h want %h", p,
                    {an, seg, dp, frameTick, wrIf.wr_ready}, {expAn, expSeg, expDp, expTick, expReady});
            end
            if ($urandom_range(0, 7) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 7) == 0) enable = 4'($urandom);
            wrIf.wr_valid = ($urandom_range(0, 15) == 0);
            wrIf.wr_data  = 16'($urandom);
            wrIf.wr_dp    = 4'($urandom);
        end
        wrIf.wr_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        brightness = 4'd15; enable = 4'hF; wrIf.wr_valid = 1'b0;
        wait_frame_start(ok);
        nCmp++; if (!ok) begin nBad++; $display("FAIL rm_wait_tick: got none want frame_tick"); end
        wait_frame_start(ok);
        nCmp++; if (!ok) begin nBad++; $display("FAIL rm_wait_tick2: got none want frame_tick"); end
        repeat (20) @(negedge clk);
        nCmp++;
        if (an !== 4'hE) begin nBad++; $display("FAIL rm_lit_before: got an=%h want e", an); end
        #1 rstN = 1'b0;
        #1;
        nCmp++;
        if ({an, seg, dp, wrIf.wr_ready, frameTick} !== {4'hF, 7'h7F, 1'b1, 1'b1, 1'b0}) begin
            nBad++; $display("FAIL rm_async: got an=%h seg=%h dp=%b rdy=%b tick=%b want F 7f 1 1 0",
                             an, seg, dp, wrIf.wr_ready, frameTick);
        end
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        nCmp++;
        if (frameTick !== 1'b1) begin nBad++; $display("FAIL rm_first_tick: got %b want 1", frameTick); end
        for (int p = 1; p < FRAME; p++) begin
            @(negedge clk);
            nCmp++;
            if ({an, seg, dp, frameTick, wrIf.wr_ready} !== {expAn, expSeg, expDp, expTick, expReady}) begin
                nBad++; $display("FAIL rm_model p=%0d: got %h want %h", p,
                    {an, seg, dp, frameTick, wrIf.wr_ready}, {expAn, expSeg, expDp, expTick, expReady});
            end
            if (p % SLOT == 4) begin
                nCmp++;
                if ({an, seg, dp} !== {anSeq[p/SLOT], 7'h40, 1'b1}) begin
                    nBad++; $display("FAIL rm_zero_digit%0d: got an=%h seg=%h dp=%b want %h 40 1",
                                     p/SLOT, an, seg, dp, anSeq[p/SLOT]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_decode();
        test_brightness();
        test_handshake();
        test_boundary_write();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
